// File: rtl/hdcpu_timing_pkg.sv
// Shared types and constants for the timing sequencer.
//   state_e    : sequencer state (HALT, RUN)
//   PH_T*      : phase register encoding
//   W_*        : one-hot beat values, W[3:1] mapped onto bits [2:0]
//   next_beat  : beat chosen at the beat-end cycle from SHORT/LONG
package hdcpu_timing_pkg;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] PH_T1 = 2'd0;
    localparam logic [1:0] PH_T2 = 2'd1;
    localparam logic [1:0] PH_T3 = 2'd2;

    localparam logic [2:0] W_1 = 3'b001;
    localparam logic [2:0] W_2 = 3'b010;
    localparam logic [2:0] W_3 = 3'b100;

    // SHORT only matters in W1 and wins over LONG there; LONG only matters in W2.
    // Any illegal beat value recovers to W1 so W can never stay zero or multi-hot.
    function automatic logic [2:0] next_beat(input logic [2:0] w,
                                             input logic       short_req,
                                             input logic       long_req);
        logic [2:0] nb;
        nb = W_1;
        case (w)
            W_1:     nb = short_req ? W_1 : W_2;
            W_2:     nb = long_req  ? W_3 : W_1;
            W_3:     nb = W_1;
            default: nb = W_1;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/qd_edge_sync.sv
// QD start-button conditioning: synchronizer, debounce filter, rising-edge pulse.
// Ports:
//   clk_i    in  system clock
//   clr_n_i  in  synchronous active-low reset
//   qd_i     in  raw asynchronous button level
//   edge_o   out one-cycle pulse when the filtered level rises
// A new level is accepted after DEBOUNCE_CNT consecutive synced samples that
// differ from the current filtered level; any agreeing sample restarts the count.
module qd_edge_sync #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic clk_i,
    input  logic clr_n_i,
    input  logic qd_i,
    output logic edge_o
);

    localparam int             DW      = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0]  DB_LOAD = DW'(DEBOUNCE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   level_dly_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Down-counter: reloaded whenever the synced input agrees with the filtered
    // level, terminal count on the DEBOUNCE_CNT-th disagreeing sample.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], qd_i};
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (synced == level_q) begin
            db_cnt_d = DB_LOAD;
        end else if (db_cnt_q == '0) begin
            level_d  = synced;
            db_cnt_d = DB_LOAD;
        end else begin
            db_cnt_d = db_cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            sync_q      <= '0;
            db_cnt_q    <= DB_LOAD;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            db_cnt_q    <= db_cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    assign edge_o = level_q & ~level_dly_q;

endmodule

// File: rtl/timing_sequencer.sv
// Beat/phase generator answering the controller's SHORT/LONG/STOP handshake.
// Ports:
//   CLK      in  system clock
//   CLR      in  synchronous active-low reset
//   QD       in  start button (asynchronous level); accepted rising edge starts/resumes
//   SHORT    in  end the cycle after W1 (sampled at beat-end only)
//   LONG     in  extend the cycle to W3 (sampled at beat-end only)
//   STOP     in  halt after the current beat (sampled at beat-end only)
//   DP       in  single-step: treated as STOP at beat-end (only with TIMING_SINGLE_STEP_EN)
//   T1..T3   out one-hot phase strobes, all low while halted
//   W        out one-hot beat W[3:1]
//   RUNNING  out high while phases are issued
// Build option: define TIMING_SINGLE_STEP_EN to add the DP input.
//
// state | meaning
// ------+---------------------------------------------------------------
// HALT  | no phases issued, W held; waits for an accepted QD rising edge
// RUN   | T1 -> T2 -> T3, PHASE_CYCLES cycles each; beat chosen at T3 end
module timing_sequencer
    import hdcpu_timing_pkg::*;
#(
    parameter int PHASE_CYCLES = 1,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       QD,
    input  logic       SHORT,
    input  logic       LONG,
    input  logic       STOP,
`ifdef TIMING_SINGLE_STEP_EN
    input  logic       DP,
`endif
    output logic       T1,
    output logic       T2,
    output logic       T3,
    output logic [2:0] W,
    output logic       RUNNING
);

    localparam int            CW      = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] PC_LAST = CW'(PHASE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    w_q, w_d;
    logic          start_q, start_d;
    logic          qd_edge;
    logic          halt_req;
    logic          phase_last;

    qd_edge_sync #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_qd_edge_sync (
        .clk_i   (CLK),
        .clr_n_i (CLR),
        .qd_i    (QD),
        .edge_o  (qd_edge)
    );

`ifdef TIMING_SINGLE_STEP_EN
    assign halt_req = STOP | DP;
`else
    assign halt_req = STOP;
`endif

    assign phase_last = (pcnt_q == PC_LAST);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pcnt_d  = pcnt_q;
        w_d     = w_q;
        // Edges are only captured while halted. While running (including the
        // beat-end cycle that samples STOP) they are dropped, never queued.
        start_d = qd_edge && (state_q == HALT);

        case (state_q)
            HALT: begin
                pcnt_d  = '0;
                phase_d = PH_T1;
                if (start_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (phase_last) begin
                    pcnt_d = '0;
                    case (phase_q)
                        PH_T1:   phase_d = PH_T2;
                        PH_T2:   phase_d = PH_T3;
                        default: begin
                            // Beat-end cycle: the only place SHORT/LONG/STOP are looked at.
                            phase_d = PH_T1;
                            w_d     = next_beat(w_q, SHORT, LONG);
                            if (halt_req) begin
                                state_d = HALT;
                            end
                        end
                    endcase
                end else begin
                    pcnt_d = pcnt_q + CW'(1);
                end
            end
            default: begin
                state_d = HALT;
                phase_d = PH_T1;
                pcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q <= HALT;
            phase_q <= PH_T1;
            pcnt_q  <= '0;
            w_q     <= W_1;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pcnt_q  <= pcnt_d;
            w_q     <= w_d;
            start_q <= start_d;
        end
    end

    assign RUNNING = (state_q == RUN);
    assign T1      = RUNNING && (phase_q == PH_T1);
    assign T2      = RUNNING && (phase_q == PH_T2);
    assign T3      = RUNNING && (phase_q == PH_T3);
    assign W       = w_q;

endmodule

// File: tb/tb_timing_sequencer.sv
module tb_timing_sequencer;

    localparam int P = 1;
    localparam int S = 2;
    localparam int D = 4;
`ifdef TIMING_SINGLE_STEP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       QD = 1'b0;
    logic       SHORT = 1'b0;
    logic       LONG = 1'b0;
    logic       STOP = 1'b0;
`ifdef TIMING_SINGLE_STEP_EN
    logic       DP = 1'b0;
`endif
    logic       T1, T2, T3, RUNNING;
    logic [2:0] W;

    always #5 CLK = ~CLK;

    timing_sequencer #(
        .PHASE_CYCLES (P),
        .SYNC_STAGES  (S),
        .DEBOUNCE_CNT (D)
    ) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .QD      (QD),
        .SHORT   (SHORT),
        .LONG    (LONG),
        .STOP    (STOP),
`ifdef TIMING_SINGLE_STEP_EN
        .DP      (DP),
`endif
        .T1      (T1),
        .T2      (T2),
        .T3      (T3),
        .W       (W),
        .RUNNING (RUNNING)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] w;
        int         start;
    } beat_t;
    beat_t exp_q[$];

    // Reference model: beat numbers 1..3, halt flag, accepted QD level,
    // and a history of the QD level presented before each rising edge.
    int m_w     = 1;
    bit m_halt  = 1'b1;
    bit m_filt  = 1'b0;
    int m_start = 0;
    bit qd_hist [0:8191];
    int p_short = 0, p_long = 0, p_stop = 0, p_dp = 0;

    function automatic logic [2:0] beat_vec(input int n);
        return 3'(1 << (n - 1));
    endfunction

    function automatic int ref_next(input int n, input bit s, input bit l);
        if (n == 1) return s ? 1 : 2;
        if (n == 2) return l ? 3 : 1;
        return 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // One clock cycle of stimulus, called at a negedge; inputs set here are
    // sampled at the next rising edge. Model is advanced for the same cycle.
    task automatic step(input bit clr_v, input bit qd_v);
        int c;
        bit all_diff;
        bit s, l, st, dpv;
        c = cyc;
        qd_hist[c] = qd_v;
        QD    = qd_v;
        CLR   = clr_v;
        SHORT = 1'($urandom_range(1));
        LONG  = 1'($urandom_range(1));
        STOP  = 1'($urandom_range(1));
`ifdef TIMING_SINGLE_STEP_EN
        DP    = 1'($urandom_range(1));
`endif
        if (!clr_v) begin
            m_w    = 1;
            m_halt = 1'b1;
            m_filt = 1'b0;
        end else begin
            // Level accepted at the edge just past if the last D synced samples all differ.
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) begin
                int k;
                bit h;
                k = c - 1 - S - j;
                h = (k >= 0) ? qd_hist[k] : 1'b0;
                if (h == m_filt) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_filt = !m_filt;
                if (m_filt && m_halt) begin
                    m_halt  = 1'b0;
                    m_start = c + 2;
                    exp_q.push_back('{w: beat_vec(m_w), start: c + 2});
                end
            end
            if (!m_halt && c == m_start + 3 * P - 1) begin
                s   = ($urandom_range(99) < p_short);
                l   = ($urandom_range(99) < p_long);
                st  = ($urandom_range(99) < p_stop);
                dpv = ($urandom_range(99) < p_dp);
                SHORT = s;
                LONG  = l;
                STOP  = st;
`ifdef TIMING_SINGLE_STEP_EN
                DP    = dpv;
`endif
                m_w = ref_next(m_w, s, l);
                if (st || (DP_EN && dpv)) begin
                    m_halt = 1'b1;
                end else begin
                    m_start = c + 1;
                    exp_q.push_back('{w: beat_vec(m_w), start: c + 1});
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n, input bit qd_v);
        for (int i = 0; i < n; i++) step(1'b1, qd_v);
    endtask

    task automatic stop_now();
        p_stop = 100;
        for (int i = 0; i < 60 && !m_halt; i++) step(1'b1, 1'b0);
        p_stop = 0;
        check("stop_reached", 32'(m_halt), 1);
    endtask

    // Monitor: pops the scoreboard at each beat start and checks phase timing.
    initial begin
        logic  p1, p2, p3;
        int    t1c;
        beat_t b;
        p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
        t1c = -100;
        forever begin
            @(negedge CLK);
            check("w_onehot", 32'($onehot(W)), 1);
            check("t_onehot0", 32'($onehot0({T1, T2, T3})), 1);
            check("running_vs_t", 32'(RUNNING), 32'(T1 | T2 | T3));
            if (T1 && !p1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got beat W=%b expected none at cycle %0d", W, cyc);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_w", 32'(W), 32'(b.w));
                    check("beat_start", 32'(cyc), 32'(b.start));
                end
                t1c = cyc;
            end
            if (T2 && !p2) check("t2_rise", 32'(cyc), 32'(t1c + P));
            if (T3 && !p3) check("t3_rise", 32'(cyc), 32'(t1c + 2 * P));
            p1 = T1; p2 = T2; p3 = T3;
        end
    end

    initial begin
        bit found;
        bit qd_lvl;
        int run_len;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check("reset_w", 32'(W), 32'(3'b001));
        check("reset_t", 32'({T1, T2, T3}), 0);
        check("reset_running", 32'(RUNNING), 0);
        idle(5, 1'b0);

        // Plain start: W alternates 001/010.
        idle(10, 1'b1);
        idle(20, 1'b0);

        // Random SHORT/LONG mix.
        p_short = 30; p_long = 50;
        idle(60, 1'b0);

        // SHORT and LONG together: W1 repeats.
        p_short = 100; p_long = 100;
        idle(12, 1'b0);

        // LONG always: W1, W2, W3 cycle.
        p_short = 0; p_long = 100;
        idle(18, 1'b0);
        p_long = 0;

        // STOP at a W1 beat-end.
        for (int i = 0; i < 50 && !m_halt; i++) begin
            p_stop = (m_w == 1) ? 100 : 0;
            step(1'b1, 1'b0);
        end
        p_stop = 0;
        check("stop_w", 32'(W), 32'(3'b010));
        idle(20, 1'b0);
        check("hold_w", 32'(W), 32'(beat_vec(m_w)));
        check("hold_t", 32'({T1, T2, T3}), 0);
        check("hold_running", 32'(RUNNING), 0);

        // Short glitch while halted: no start.
        idle(2, 1'b1);
        idle(20, 1'b0);
        check("glitch_running", 32'(RUNNING), 0);

        // Resume with held W, then a press during RUN that must be discarded.
        idle(10, 1'b1);
        idle(15, 1'b0);
        idle(10, 1'b1);
        idle(30, 1'b0);
        stop_now();
        idle(30, 1'b0);
        check("run_press_running", 32'(RUNNING), 0);

        // Reset during T2 of W2.
        idle(10, 1'b1);
        idle(5, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (!m_halt && m_w == 2 && cyc == m_start + P) found = 1'b1;
            else step(1'b1, 1'b0);
        end
        check("reset_window_found", 32'(found), 1);
        step(1'b0, 1'b0);
        check("midreset_w", 32'(W), 32'(3'b001));
        check("midreset_t", 32'({T1, T2, T3}), 0);
        check("midreset_running", 32'(RUNNING), 0);
        idle(5, 1'b0);
        idle(10, 1'b1);
        idle(15, 1'b0);

        // Random stress: random QD activity against random SHORT/LONG/STOP.
        p_short = 30; p_long = 40; p_stop = 15; p_dp = 20;
        qd_lvl = 1'b0;
        run_len = 0;
        for (int i = 0; i < 400; i++) begin
            if (run_len == 0) begin
                qd_lvl  = !qd_lvl;
                run_len = $urandom_range(12, 1);
            end
            run_len--;
            step(1'b1, qd_lvl);
        end
        p_short = 0; p_long = 0; p_stop = 0; p_dp = 0;
        idle(15, 1'b0);
        stop_now();
        idle(20, 1'b0);

`ifdef TIMING_SINGLE_STEP_EN
        // Single-step: one beat per press.
        p_dp = 100;
        idle(10, 1'b1);
        idle(30, 1'b0);
        check("single_step_running", 32'(RUNNING), 0);
        idle(10, 1'b1);
        idle(30, 1'b0);
        p_dp = 0;
`endif

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
